// File: rtl/stfq_pkg.sv
// Shared STFQ types and the wrap-around "later" comparison used by the rank
// computer and the scheduler-side bench.
package stfq_pkg;

  localparam int DEF_NUM_FLOWS = 8;
  localparam int DEF_LEN_W     = 16;

  typedef logic [31:0] rank_t;
  typedef logic [3:0]  shift_t;

  // Serial-number comparison: a wins only when strictly ahead of b modulo 2^32.
  function automatic rank_t later(input rank_t a, input rank_t b);
    rank_t diff;
    diff = a - b;
    return ($signed(diff) > 0) ? a : b;
  endfunction

endpackage

// File: rtl/stfq_rank_computer_if.sv
// Descriptor-in / push-out / virtual-time bus of the STFQ rank computer.
// The cfg_* weight-write signals exist only when STFQ_WEIGHT_CFG_EN is defined.
interface stfq_rank_computer_if
  import stfq_pkg::*;
#(
  parameter int NUM_FLOWS = DEF_NUM_FLOWS,
  parameter int LEN_W     = DEF_LEN_W
) ();
  localparam int FLOW_W = $clog2(NUM_FLOWS);

  logic              in_valid;
  logic              in_ready;
  logic [FLOW_W-1:0] in_flow;
  logic [LEN_W-1:0]  in_len;
  logic [31:0]       in_value;
  logic              out_push;
  rank_t             out_rank;
  logic [31:0]       out_value;
  logic              out_can_push;
  logic              vt_valid;
  rank_t             vt_value;
`ifdef STFQ_WEIGHT_CFG_EN
  logic              cfg_we;
  logic [FLOW_W-1:0] cfg_flow;
  shift_t            cfg_shift;

  modport master (
    output in_valid, in_flow, in_len, in_value, out_can_push, vt_valid, vt_value,
           cfg_we, cfg_flow, cfg_shift,
    input  in_ready, out_push, out_rank, out_value
  );
  modport slave (
    input  in_valid, in_flow, in_len, in_value, out_can_push, vt_valid, vt_value,
           cfg_we, cfg_flow, cfg_shift,
    output in_ready, out_push, out_rank, out_value
  );
`else
  modport master (
    output in_valid, in_flow, in_len, in_value, out_can_push, vt_valid, vt_value,
    input  in_ready, out_push, out_rank, out_value
  );
  modport slave (
    input  in_valid, in_flow, in_len, in_value, out_can_push, vt_valid, vt_value,
    output in_ready, out_push, out_rank, out_value
  );
`endif

endinterface

// File: rtl/stfq_flow_table.sv
// Per-flow finish tags F[] and weight shifts S[]; one combinational read port,
// one accept-update write port, and (with STFQ_WEIGHT_CFG_EN) a shift write port.
module stfq_flow_table
  import stfq_pkg::*;
#(
  parameter int NUM_FLOWS = DEF_NUM_FLOWS,
  parameter int FLOW_W    = $clog2(NUM_FLOWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOW_W-1:0] i_rd_flow,
  output rank_t             o_rd_finish,
  output shift_t            o_rd_shift,
  input  logic              i_upd_en,
  input  logic [FLOW_W-1:0] i_upd_flow,
  input  rank_t             i_upd_finish
`ifdef STFQ_WEIGHT_CFG_EN
  ,
  input  logic              i_cfg_we,
  input  logic [FLOW_W-1:0] i_cfg_flow,
  input  shift_t            i_cfg_shift
`endif
);

  rank_t r_finish [NUM_FLOWS];

  assign o_rd_finish = r_finish[i_rd_flow];

  // NOTE: the table is a small flop array, so it can be cleared by reset;
  // a RAM-style memory could not be, and stale tags would leak across reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) r_finish[f] <= '0;
    end else if (i_upd_en) begin
      r_finish[i_upd_flow] <= i_upd_finish;
    end
  end

`ifdef STFQ_WEIGHT_CFG_EN
  shift_t r_shift [NUM_FLOWS];

  assign o_rd_shift = r_shift[i_rd_flow];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < NUM_FLOWS; f++) r_shift[f] <= '0;
    end else if (i_cfg_we) begin
      r_shift[i_cfg_flow] <= i_cfg_shift;
    end
  end
`else
  assign o_rd_shift = '0;
`endif

endmodule

// File: rtl/stfq_rank_computer.sv
// STFQ start-tag (rank) computer feeding a flow scheduler push port through a
// one-deep holding register. Weighted flows require STFQ_WEIGHT_CFG_EN.
module stfq_rank_computer
  import stfq_pkg::*;
#(
  parameter int NUM_FLOWS = DEF_NUM_FLOWS,
  parameter int LEN_W     = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  stfq_rank_computer_if.slave  bus
);

  rank_t            r_vtime;
  logic             r_pend;
  rank_t            r_rank;
  logic [31:0]      r_value;

  rank_t            w_rd_finish;
  shift_t           w_shift;
  rank_t            w_start;
  rank_t            w_finish;
  logic [LEN_W-1:0] w_len;
  logic             w_accept;
  logic             w_push;

  assign w_len    = bus.in_len;
  assign w_start  = later(w_rd_finish, r_vtime);
  assign w_finish = w_start + (32'(w_len) >> w_shift);

  assign bus.in_ready = !r_pend || bus.out_can_push;
  assign w_accept     = bus.in_valid && bus.in_ready && !rst;
  // Reset also suppresses a push of the descriptor being discarded.
  assign w_push       = r_pend && bus.out_can_push && !rst;

  assign bus.out_push  = w_push;
  assign bus.out_rank  = r_rank;
  assign bus.out_value = r_value;

  stfq_flow_table #(
    .NUM_FLOWS (NUM_FLOWS)
  ) u_flow_table (
    .clk          (clk),
    .rst          (rst),
    .i_rd_flow    (bus.in_flow),
    .o_rd_finish  (w_rd_finish),
    .o_rd_shift   (w_shift),
    .i_upd_en     (w_accept),
    .i_upd_flow   (bus.in_flow),
    .i_upd_finish (w_finish)
`ifdef STFQ_WEIGHT_CFG_EN
    ,
    .i_cfg_we     (bus.cfg_we),
    .i_cfg_flow   (bus.cfg_flow),
    .i_cfg_shift  (bus.cfg_shift)
`endif
  );

  // A same-cycle accept refills the register behind the departing push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 1'b0;
      r_rank  <= '0;
      r_value <= '0;
    end else if (w_accept) begin
      r_pend  <= 1'b1;
      r_rank  <= w_start;
      r_value <= bus.in_value;
    end else if (w_push) begin
      r_pend  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vtime <= '0;
    end else if (bus.vt_valid) begin
      r_vtime <= later(bus.vt_value, r_vtime);
    end
  end

endmodule

// File: tb/tb_stfq_rank_computer.sv
// Self-checking bench for stfq_rank_computer: directed scenarios plus random
// traffic against a queue-based STFQ reference model (STFQ_WEIGHT_CFG_EN aware).
module tb_stfq_rank_computer;

  localparam int NF = 8;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stfq_rank_computer_if #(.NUM_FLOWS(NF), .LEN_W(LW)) bus ();

  stfq_rank_computer #(.NUM_FLOWS(NF), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: virtual time, finish tags, shifts and the queue of
  // descriptors accepted but not yet pushed.
  typedef struct { logic [31:0] rank; logic [31:0] value; } push_t;
  logic [31:0] m_v;
  logic [31:0] m_f [NF];
  int          m_s [NF];
  push_t       m_q [$];
  logic [31:0] next_val = 32'h1000;

  function automatic logic [31:0] m_later(input logic [31:0] a, input logic [31:0] b);
    int signed d;
    d = int'(a - b);
    return (d > 0) ? a : b;
  endfunction

  task automatic drive_idle();
    bus.in_valid     = 1'b0;
    bus.in_flow      = '0;
    bus.in_len       = '0;
    bus.in_value     = '0;
    bus.out_can_push = 1'b0;
    bus.vt_valid     = 1'b0;
    bus.vt_value     = '0;
`ifdef STFQ_WEIGHT_CFG_EN
    bus.cfg_we       = 1'b0;
    bus.cfg_flow     = '0;
    bus.cfg_shift    = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_v = '0;
    for (int f = 0; f < NF; f++) begin
      m_f[f] = '0;
      m_s[f] = 0;
    end
    m_q.delete();
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_push", 32'(bus.out_push), 32'd0);
  endtask

  // One clock cycle: apply inputs at negedge, check outputs, advance the model.
  task automatic cycle(input bit v, input int flow, input int len, input bit cp,
                       input bit vtv = 0, input logic [31:0] vtval = '0,
                       input bit cwe = 0, input int cflow = 0, input int cshift = 0);
    bit exp_ready, exp_push;
    logic [31:0] start;
    @(negedge clk);
    drive_idle();
    bus.in_valid     = v;
    bus.in_flow      = 3'(flow);
    bus.in_len       = 16'(len);
    bus.in_value     = next_val;
    bus.out_can_push = cp;
    bus.vt_valid     = vtv;
    bus.vt_value     = vtval;
`ifdef STFQ_WEIGHT_CFG_EN
    bus.cfg_we       = cwe;
    bus.cfg_flow     = 3'(cflow);
    bus.cfg_shift    = 4'(cshift);
`endif
    #1;
    exp_ready = (m_q.size() == 0) || cp;
    exp_push  = (m_q.size() != 0) && cp;
    check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("out_push", 32'(bus.out_push), 32'(exp_push));
    if (exp_push) begin
      check("out_rank", bus.out_rank, m_q[0].rank);
      check("out_value", bus.out_value, m_q[0].value);
      void'(m_q.pop_front());
    end
    if (v && exp_ready) begin
      start = m_later(m_f[flow], m_v);
      m_f[flow] = start + (32'(len) >> m_s[flow]);
      m_q.push_back('{rank: start, value: next_val});
      next_val++;
    end
    if (vtv) m_v = m_later(vtval, m_v);
`ifdef STFQ_WEIGHT_CFG_EN
    if (cwe) m_s[cflow] = cshift;
`else
    if (cwe) m_s[cflow] = m_s[cflow] + 0 * cshift;
`endif
  endtask

  initial begin
    drive_idle();

    // Back-to-back same-flow accepts see the freshly written finish tag.
    do_reset();
    cycle(1, 0, 100, 1);
    cycle(1, 0, 50, 1);
    cycle(0, 0, 0, 1);
    cycle(1, 0, 7, 1);
    cycle(0, 0, 0, 1);

    // Different flows at equal V share rank 0; V update moves a new flow forward.
    do_reset();
    cycle(1, 1, 100, 1);
    cycle(1, 2, 100, 1);
    cycle(0, 0, 0, 1, 1, 32'd100);
    cycle(1, 3, 20, 1);
    cycle(0, 0, 0, 1);

    // Stall five cycles with a held descriptor and a waiting one, then release.
    cycle(1, 4, 10, 0);
    for (int i = 0; i < 5; i++) cycle(1, 5, 10, 0);
    cycle(1, 5, 10, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Wrap-around: walk V to 0xFFFF_FFE0, set F[0]=0xFFFF_FFF0, then len 0x20.
    do_reset();
    cycle(0, 0, 0, 1, 1, 32'h4000_0000);
    cycle(0, 0, 0, 1, 1, 32'h8000_0000);
    cycle(1, 0, 16'h10, 1);
    cycle(0, 0, 0, 1, 1, 32'hC000_0000);
    cycle(0, 0, 0, 1, 1, 32'hFFFF_FFE0);
    cycle(1, 0, 16'h10, 1);
    cycle(1, 0, 16'h20, 1);
    cycle(0, 0, 0, 1, 1, 32'h0000_0008);
    cycle(1, 5, 1, 1);
    cycle(1, 0, 1, 1);
    cycle(0, 0, 0, 1);

    // A V update in the same cycle as an accept is not seen by that accept.
    cycle(1, 6, 5, 1, 1, 32'h0000_0200);
    cycle(1, 7, 5, 1);
    cycle(0, 0, 0, 1);

`ifdef STFQ_WEIGHT_CFG_EN
    // Shift 2 on flow 1; a shift write coincident with an accept uses the old shift.
    do_reset();
    cycle(0, 0, 0, 1, 0, '0, 1, 1, 2);
    cycle(1, 1, 400, 1);
    cycle(1, 1, 400, 1);
    cycle(1, 1, 400, 1, 0, '0, 1, 1, 0);
    cycle(1, 1, 4, 1);
    cycle(1, 1, 4, 1);
    cycle(0, 0, 0, 1);
`endif

    // Reset while stalled discards the held descriptor and all tags.
    cycle(1, 2, 300, 0);
    cycle(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    cycle(1, 2, 9, 1);
    cycle(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] vt;
      vt = ($urandom_range(0, 7) == 0) ? $urandom() : m_v + $urandom_range(0, 400);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, NF - 1),
            ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 16'hFFFF),
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 4) == 0, vt,
            $urandom_range(0, 9) == 0, $urandom_range(0, NF - 1), $urandom_range(0, 15));
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stfq_rank_computer.md
STFQ_RANK_COMPUTER -- requirements
Module: stfq_rank_computer

Interface
REQ-001 Parameter NUM_FLOWS, default 8, number of flows tracked; SHALL be >= 2.
REQ-002 Parameter LEN_W, default 16, packet length width in bytes.
REQ-003 clk  input  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  packet descriptor offered.
REQ-006 in_ready  output  1  descriptor accepted when in_valid && in_ready.
REQ-007 in_flow  input  $clog2(NUM_FLOWS)  flow id.
REQ-008 in_len  input  LEN_W  packet length.
REQ-009 in_value  input  32  payload handle passed through.
REQ-010 out_push  output  1  one-cycle push strobe to downstream flow scheduler push port 1.
REQ-011 out_rank  output  32  rank (STFQ start tag) for the push.
REQ-012 out_value  output  32  payload handle for the push.
REQ-013 out_can_push  input  1  scheduler has room for one element.
REQ-014 vt_valid  input  1  virtual-time update strobe from dequeue side.
REQ-015 vt_value  input  32  start tag of the departing packet.
REQ-016 cfg_we, cfg_flow, cfg_shift  input  1/$clog2(NUM_FLOWS)/4  per-flow weight-shift write (present only under REQ-033).

Function
REQ-017 State: virtual time V (32 b), per-flow finish tag F[f] (32 b), per-flow shift S[f] (4 b), one output holding register (pend, rank, value).
REQ-018 in_ready SHALL equal !pend || out_can_push; combinational, no dependence on in_valid.
REQ-019 On accept: start = later(F[in_flow], V); F[in_flow] <= start + (in_len >> S[in_flow]) zero-extended to 32 b, modulo 2^32; pend <= 1, rank <= start, value <= in_value.
REQ-020 later(a,b) SHALL be a if $signed(a - b) > 0, else b (wrap-around serial comparison); ties select b.
REQ-021 out_push = pend && out_can_push; out_rank/out_value driven from holding register; latency accept-to-earliest-push 1 cycle.
REQ-022 Push without new accept clears pend; push with same-cycle accept keeps pend = 1 with new contents (full throughput, 1 descriptor/cycle).
REQ-023 pend && !out_can_push: holding register and in_ready hold; descriptor SHALL NOT be lost or duplicated.
REQ-024 Back-to-back same-flow accepts SHALL see the F value written by the prior accept (table written at accept; no stale read).
REQ-025 vt_valid: V <= later(vt_value, V); V never moves backwards in serial order.
REQ-026 vt_valid coincident with accept: accept uses pre-update V; update visible next cycle.
REQ-027 cfg_we coincident with accept of same flow: accept uses old S; new S visible next cycle.
REQ-028 in_len = 0: start computed normally, F unchanged in value (F <= start).

Reset
REQ-029 rst SHALL clear V, all F[f], all S[f] and pend to 0; out_push = 0 and in_ready = 1 in the first cycle after reset.
REQ-030 rst mid-stall SHALL discard the held descriptor; no out_push issued for it.
REQ-031 rst dominates all inputs in the same cycle.

Configuration
REQ-032 Macro STFQ_WEIGHT_CFG_EN selects configurable weights.
REQ-033 Defined: cfg_* ports exist; cfg_we writes S[cfg_flow] <= cfg_shift.
REQ-034 Undefined: cfg_* ports absent; S[f] constant 0 (finish = start + in_len).

Structure
REQ-035 Package stfq_pkg SHALL hold rank_t (32 b), shift_t (4 b), function later(), default NUM_FLOWS/LEN_W constants; shared with the scheduler-side bench.
REQ-036 One sub-module stfq_flow_table SHALL hold F[] and S[] with one read port (in_flow) and write ports for accept update and cfg write.

Verification
REQ-037 Reset, V=0; flow 0 len 100 then flow 0 len 50 back-to-back, out_can_push=1 -> pushes rank 0 then 100, F[0]=150.
REQ-038 Flow 1 len 100, flow 2 len 100, same cycle stream -> both rank 0; then vt_value=100 -> next flow 3 packet rank 100.
REQ-039 out_can_push=0 for 5 cycles with pend set -> in_ready=0, out_push=0 throughout, rank held; release -> exactly one push.
REQ-040 F[0]=0xFFFF_FFF0, V=0xFFFF_FFE0, len 0x20 -> rank 0xFFFF_FFF0, F[0]=0x0000_0010; later vt_value=0x0000_0008 accepted as later than V.
REQ-041 STFQ_WEIGHT_CFG_EN: S[1]=2, flow 1 len 400 twice -> ranks 0, 100; cfg write and accept same cycle -> old shift used.
REQ-042 rst asserted while pend=1, out_can_push=0 -> after reset no push for held descriptor, V=0, F all 0.
